// File: rtl/reg_file_wb_sb.sv
// Write-back register file with bypassed read ports, per-register pending
// scoreboard and a multi-cycle bulk-clear sweep.
module reg_file_wb_sb #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned ADDR_W   = 3,
   parameter int unsigned ZERO_REG = 0
) (
   input  logic                        CLK_WB,
   input  logic                        RESET_N,
   input  logic                        WB_VALID,
   input  logic [ADDR_W-1:0]           WB_ADDR,
   input  logic [DATA_W-1:0]           WB_DATA,
   output logic                        WB_READY,
   input  logic                        RSV_VALID,
   input  logic [ADDR_W-1:0]           RSV_ADDR,
   input  logic [ADDR_W-1:0]           RD_A_ADDR,
   output logic [DATA_W-1:0]           RD_A_DATA,
   output logic                        RD_A_PEND,
   input  logic [ADDR_W-1:0]           RD_B_ADDR,
   output logic [DATA_W-1:0]           RD_B_DATA,
   output logic                        RD_B_PEND,
   input  logic                        CLR_REQ,
   output logic                        CLR_BUSY,
   output logic                        CLR_DONE,
   output logic [(2**ADDR_W)-1:0]      PEND,
   output logic [(2**ADDR_W)*DATA_W-1:0] REG_FLAT
);

   localparam int unsigned N_REGS = 2**ADDR_W;
   localparam bit          ZR     = (ZERO_REG != 0);

   typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_idx;
   logic [DATA_W-1:0]   r_regs [N_REGS];
   logic [N_REGS-1:0]   r_pend;
   logic                r_done;

   logic                w_idle;
   logic                w_wb_acc;
   logic                w_rsv;
   logic                w_a_hit;
   logic                w_b_hit;

   // Index 0 is hard-wired when ZERO_REG is set, so writes and reserves to it vanish here.
   assign w_idle   = (r_state == ST_IDLE);
   assign w_wb_acc = WB_VALID  & w_idle & ~(ZR && (WB_ADDR  == '0));
   assign w_rsv    = RSV_VALID & w_idle & ~(ZR && (RSV_ADDR == '0));

   assign WB_READY = w_idle;
   assign CLR_BUSY = (r_state == ST_SWEEP);
   assign CLR_DONE = r_done;
   assign PEND     = r_pend;

   assign w_a_hit   = w_wb_acc && (WB_ADDR == RD_A_ADDR);
   assign w_b_hit   = w_wb_acc && (WB_ADDR == RD_B_ADDR);
   assign RD_A_DATA = w_a_hit ? WB_DATA :
                      (ZR && (RD_A_ADDR == '0)) ? '0 : r_regs[RD_A_ADDR];
   assign RD_A_PEND = w_a_hit ? 1'b0 : r_pend[RD_A_ADDR];
   assign RD_B_DATA = w_b_hit ? WB_DATA :
                      (ZR && (RD_B_ADDR == '0)) ? '0 : r_regs[RD_B_ADDR];
   assign RD_B_PEND = w_b_hit ? 1'b0 : r_pend[RD_B_ADDR];

   for (genvar g = 0; g < N_REGS; g++) begin : g_flat
      assign REG_FLAT[g*DATA_W +: DATA_W] = r_regs[g];
   end

   // State, register array, scoreboard and clear sequencer.
   always_ff @(posedge CLK_WB) begin
      if (!RESET_N) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_pend  <= '0;
         r_done  <= 1'b0;
         for (int i = 0; i < N_REGS; i++) r_regs[i] <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_wb_acc) begin
                  r_regs[WB_ADDR] <= WB_DATA;
                  r_pend[WB_ADDR] <= 1'b0;
               end
               // Reserve is assigned last so it wins over a same-address writeback.
               if (w_rsv) r_pend[RSV_ADDR] <= 1'b1;
               if (CLR_REQ) begin
                  r_state <= ST_SWEEP;
                  r_idx   <= '0;
               end
            end
            ST_SWEEP: begin
               r_regs[r_idx] <= '0;
               r_pend[r_idx] <= 1'b0;
               r_idx         <= r_idx + ADDR_W'(1);
               if (r_idx == ADDR_W'(N_REGS - 1)) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
